// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_pkg
//  Purpose  : 640x480 1-bpp framebuffer timing and sizing constants.
//  Revision : 1.0  initial release
// ============================================================================
package vga_fb_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int ADDR_W   = 15;

    localparam int WPL      = H_ACTIVE / 16;
    localparam int FB_WORDS = WPL * V_ACTIVE;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter_if
//  Purpose  : Host valid/ready write (optionally read) port of the arbiter.
//             Read signals exist only when FB_HOST_READ_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_fb_arbiter_if
    import vga_fb_pkg::*;
();

    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [15:0]       host_wdata;
`ifdef FB_HOST_READ_EN
    logic              host_we;
    logic              host_rvalid;
    logic [15:0]       host_rdata;

    modport master (
        output host_valid, host_addr, host_wdata, host_we,
        input  host_ready, host_rvalid, host_rdata
    );
    modport slave (
        input  host_valid, host_addr, host_wdata, host_we,
        output host_ready, host_rvalid, host_rdata
    );
`else
    modport master (
        output host_valid, host_addr, host_wdata,
        input  host_ready
    );
    modport slave (
        input  host_valid, host_addr, host_wdata,
        output host_ready
    );
`endif

endinterface
`default_nettype wire

// File: rtl/vga_fb_scan_addr.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_scan_addr
//  Purpose  : Decodes the scanout fetch slot from the timing counters and
//             tracks the word address of the current line's first group.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_scan_addr
    import vga_fb_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [9:0]        i_h_count,
    input  wire logic [9:0]        i_v_count,
    output logic                   o_scan_slot,
    output logic [ADDR_W-1:0]      o_scan_addr
);

    localparam logic [9:0]        c_H_SLOT_END  = 10'(H_ACTIVE - 2);
    localparam logic [9:0]        c_H_NEXT_SLOT = 10'(H_TOTAL - 2);
    localparam logic [9:0]        c_H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]        c_V_ACTIVE    = 10'(V_ACTIVE);
    localparam logic [9:0]        c_V_ACT_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]        c_V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] c_WPL         = ADDR_W'(WPL);

    logic [ADDR_W-1:0] r_line_base;
    logic              w_cur_slot;
    logic              w_next_slot;
    logic              w_v_last;
    logic [5:0]        w_group;

    assign w_v_last    = (i_v_count == c_V_LAST);
    assign w_cur_slot  = (i_h_count[3:0] == 4'd14) && (i_h_count < c_H_SLOT_END)
                         && (i_v_count < c_V_ACTIVE);
    assign w_next_slot = (i_h_count == c_H_NEXT_SLOT)
                         && (w_v_last || (i_v_count < c_V_ACT_LAST));
    // Slot sits two pixels before its group, so (h+2)/16 is simply h/16 + 1.
    assign w_group     = i_h_count[9:4] + 6'd1;

    always_comb begin
        o_scan_slot = 1'b0;
        o_scan_addr = r_line_base + ADDR_W'(w_group);
        if (w_cur_slot) begin
            o_scan_slot = 1'b1;
        end else if (w_next_slot) begin
            o_scan_slot = 1'b1;
            o_scan_addr = w_v_last ? '0 : (r_line_base + c_WPL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_base <= '0;
        end else if (i_h_count == c_H_LAST) begin
            if (w_v_last) begin
                r_line_base <= '0;
            end else if (i_v_count < c_V_ACT_LAST) begin
                r_line_base <= r_line_base + c_WPL;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter
//  Purpose  : Single-port video RAM arbiter: one scanout fetch per 16 pixels,
//             all other cycles granted to the host. FB_HOST_READ_EN adds reads.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  wire logic              clk_25mhz,
    input  wire logic              reset,
    input  wire logic [9:0]        h_count,
    input  wire logic [9:0]        v_count,
    output logic                   video,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_we,
    output logic [15:0]            ram_wdata,
    input  wire logic [15:0]       ram_rdata,
    vga_fb_arbiter_if.slave        host
);

    localparam logic [ADDR_W-1:0] c_FB_WORDS = ADDR_W'(FB_WORDS);
    localparam logic [9:0]        c_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0]        c_V_ACTIVE = 10'(V_ACTIVE);

    logic              w_scan_slot;
    logic [ADDR_W-1:0] w_scan_addr;
    logic              w_accept;
    logic              w_in_range;
    logic              r_scan_d;
    logic [15:0]       r_shreg;

    vga_fb_scan_addr u_scan_addr (
        .clk         (clk_25mhz),
        .rst         (reset),
        .i_h_count   (h_count),
        .i_v_count   (v_count),
        .o_scan_slot (w_scan_slot),
        .o_scan_addr (w_scan_addr)
    );

    assign host.host_ready = !reset && !w_scan_slot;
    assign w_accept        = host.host_valid && host.host_ready;
    assign w_in_range      = (host.host_addr < c_FB_WORDS);
    assign ram_addr        = w_scan_slot ? w_scan_addr : host.host_addr;
    assign ram_wdata       = host.host_wdata;

`ifdef FB_HOST_READ_EN
    logic r_host_rvalid;
    logic r_rd_oob;

    assign ram_we           = w_accept && w_in_range && host.host_we;
    assign host.host_rvalid = r_host_rvalid;
    // Out-of-range reads still occupy the RAM cycle; their data is masked.
    assign host.host_rdata  = r_rd_oob ? 16'h0000 : ram_rdata;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_host_rvalid <= 1'b0;
            r_rd_oob      <= 1'b0;
        end else begin
            r_host_rvalid <= w_accept && !host.host_we;
            r_rd_oob      <= !w_in_range;
        end
    end
`else
    assign ram_we = w_accept && w_in_range;
`endif

    // RAM data arrives one cycle after the slot; load it then, shift otherwise.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_scan_d <= 1'b0;
            r_shreg  <= 16'h0000;
        end else begin
            r_scan_d <= w_scan_slot;
            if (r_scan_d) begin
                r_shreg <= ram_rdata;
            end else begin
                r_shreg <= {r_shreg[14:0], 1'b0};
            end
        end
    end

    assign video = r_shreg[15] && (h_count < c_H_ACTIVE) && (v_count < c_V_ACTIVE);

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter and scanout sequencer for the 640×480 1-bpp VGA path. Sits between the VGA timing core (consumes its `h_count`/`v_count`) and one synchronous single-port video RAM of 16-bit words. Steals one fixed RAM slot per 16 pixels for scanout and serialises the fetched words to `video`. Grants every remaining cycle to a host write port with a valid/ready handshake.

## Interface
- `H_ACTIVE`, 640, visible pixels per line; multiple of 16
- `V_ACTIVE`, 480, visible lines
- `H_TOTAL`, 800, clocks per line; multiple of 16
- `V_TOTAL`, 525, lines per frame
- `ADDR_W`, 15, RAM word-address width
- `clk_25mhz`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high
- `h_count`  in  10  timing-core column, 0..H_TOTAL-1
- `v_count`  in  10  timing-core line, 0..V_TOTAL-1
- `video`  out  1  pixel for current (`h_count`, `v_count`); 0 in blanking
- `ram_addr`  out  ADDR_W  RAM word address
- `ram_we`  out  1  RAM write enable
- `ram_wdata`  out  16  RAM write data
- `ram_rdata`  in  16  RAM read data, valid 1 cycle after address
- `host_valid`  in  1  host request
- `host_ready`  out  1  host request accepted this cycle when high with `host_valid`
- `host_addr`  in  ADDR_W  host word address, pixel (x,y) = word y*40 + x/16, bit 15-(x%16)
- `host_wdata`  in  16  host write data, MSB = leftmost pixel

## Operation
- Words per line `WPL` = H_ACTIVE/16 = 40. Framebuffer size `FB_WORDS` = 19200.
- Scan slot is any cycle with `h_count[3:0]`==14 and one of:
  - `h_count` < H_ACTIVE-2 and `v_count` < V_ACTIVE. Fetches group g=(h_count+2)/16 of the current line.
  - `h_count`==H_TOTAL-2 and the next line is visible. Next line is 0 when `v_count`==V_TOTAL-1, otherwise `v_count`+1. Fetches group 0 of the next line.
- Scan address = line_base + g. line_base is a register, reset 0, updated in the `h_count`==H_TOTAL-1 cycle:
  - set to 0 when `v_count`==V_TOTAL-1;
  - += WPL when `v_count` < V_ACTIVE-1;
  - otherwise held.
- The next-line fetch uses line_base+WPL, or 0 at frame wrap. No multiplier anywhere.
- Scan slot has absolute priority. `host_ready` = !reset && !scan_slot (combinational).
- On host accept:
  - `ram_addr`=`host_addr`, `ram_wdata`=`host_wdata`, `ram_we`=1.
  - If `host_addr` ≥ FB_WORDS, the request is accepted and dropped with `ram_we`=0.
- Shift register shreg[15:0], reset 0:
  - loads `ram_rdata` at the end of the cycle after a scan slot;
  - otherwise shifts left, filling with 0.
- `video` = shreg[15] && (`h_count` < H_ACTIVE) && (`v_count` < V_ACTIVE).
- Reset mid-frame clears shreg and line_base. Scanout realigns at the next frame wrap. Pixels are 0 until then, except lines whose base happens to be correct.

## Timing
- Scan slot cycle S: `ram_addr` driven. S+1: `ram_rdata` captured into shreg. S+2 (group start): pixel 16g on `video`. Zero latency relative to the counters.
- During active lines the host gets 15 of every 16 cycles. During blanking lines it gets every cycle except the frame-wrap fetch.
- A host request held through a scan slot stalls one cycle. No starvation.
- Reset values: `video`=0, `ram_we`=0, `host_ready`=0, `host_rvalid`=0.

## Configuration
- `FB_HOST_READ_EN` defined:
  - adds ports `host_we` (in 1), `host_rvalid` (out 1, registered), `host_rdata` (out 16 = `ram_rdata`);
  - an accepted request with `host_we`=0 drives `ram_we`=0 and pulses `host_rvalid` in cycle A+1;
  - an out-of-range read returns `host_rdata`=0.
- `FB_HOST_READ_EN` undefined: these ports are absent and every accepted request is a write.

## Structure
- Package `vga_fb_pkg`: timing constants, WPL, FB_WORDS, ADDR_W.
- Sub-module `vga_fb_scan_addr`: scan-slot decode plus line_base register; outputs scan_slot and scan_addr.

## Test plan
- Reset held 5 cycles mid-line -> `video`=0, `ram_we`=0, `host_ready`=0.
- RAM word 0 = 16'h8001, word 40 = 16'hFFFF -> `ram_addr`=0 at (v=524, h=798); `ram_addr`=40 at (v=0, h=798); on line 0, `video`=1 at h=0 and h=15, 0 at h=1..14; line 1, h=0..15 all 1.
- Host write addr 100, data 16'hA5A5, held from (v=10, h=14) -> `host_ready`=0 and `ram_addr`=401 at h=14; accepted at h=15 with `ram_we`=1, addr 100.
- Host write addr 19200 -> `host_ready`=1, `ram_we`=0, no RAM change.
- v=480..523 -> `host_ready` continuously 1, `video`=0; v=524 -> `host_ready`=0 only at h=798.
- With `FB_HOST_READ_EN`: read addr 40 -> `host_rvalid`=1 next cycle, `host_rdata`=16'hFFFF; read 19200 -> `host_rdata`=0.
